// File: rtl/frv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// frv_dmem_arbiter
//
// Two-port data-memory arbiter. Port 0 (LSU) and port 1 (secondary
// requester) share a single downstream dmem interface. The request path is
// purely combinational. An ID FIFO records which port each granted
// transaction came from, so in-order responses can be routed back to the
// right port.
//
// Configuration:
//   FRV_DMEM_ARB_RR_EN  defined   -> round-robin arbitration on contention
//                       undefined -> fixed priority, port 0 wins contention
//
// Parameters:
//   OUTSTANDING  maximum granted-but-unanswered transactions (power of 2, >=2)
//
// Ports:
//   g_clk, g_reset                        clock, synchronous active-high reset
//   pN_req/wen/strb/addr/wdata (in)       port N request fields
//   pN_gnt (out)                          port N request accepted downstream
//   pN_recv/error/rdata (out), pN_ack(in) port N response channel
//   dmem_req/wen/strb/addr/wdata (out)    downstream request fields
//   dmem_gnt (in)                         downstream request accepted
//   dmem_recv/error/rdata (in)            downstream response
//   dmem_ack (out)                        downstream response accepted
// ---------------------------------------------------------------------------
module frv_dmem_arbiter #(
    parameter int OUTSTANDING = 2
) (
    input  logic        g_clk,
    input  logic        g_reset,

    input  logic        p0_req,
    input  logic        p0_wen,
    input  logic [3:0]  p0_strb,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_recv,
    output logic        p0_error,
    output logic [31:0] p0_rdata,
    input  logic        p0_ack,

    input  logic        p1_req,
    input  logic        p1_wen,
    input  logic [3:0]  p1_strb,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_recv,
    output logic        p1_error,
    output logic [31:0] p1_rdata,
    input  logic        p1_ack,

    output logic        dmem_req,
    output logic        dmem_wen,
    output logic [3:0]  dmem_strb,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_recv,
    input  logic        dmem_error,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_ack
);

    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;

    logic                   lock_q;     // previous request stalled: hold sel
    logic                   sel_q;      // port selected on the previous cycle
    logic                   sel;        // port selected this cycle
    logic                   contend_pick;
    logic                   sel_req;
    logic                   push;
    logic                   pop;
    logic                   full;
    logic                   empty;
    logic                   head_id;
    logic [OUTSTANDING-1:0] id_mem;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count;

    assign full    = (count == CW'(OUTSTANDING));
    assign empty   = (count == '0);
    assign head_id = id_mem[rd_ptr];

`ifdef FRV_DMEM_ARB_RR_EN
    // Favoured port on contention; flips to the other port after each grant.
    logic prio_q;

    always_ff @(posedge g_clk) begin
        if (g_reset)
            prio_q <= 1'b0;
        else if (push)
            prio_q <= ~sel;
    end

    assign contend_pick = prio_q;
`else
    assign contend_pick = 1'b0;
`endif

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        sel = 1'b0;
        if (lock_q)
            sel = sel_q;
        else if (p0_req && p1_req)
            sel = contend_pick;
        else if (p1_req)
            sel = 1'b1;
    end

    assign sel_req  = sel ? p1_req : p0_req;
    // A full FIFO blocks the push even if a pop happens this cycle.
    assign dmem_req = sel_req && !full && !g_reset;
    assign push     = dmem_req && dmem_gnt;
    assign pop      = !empty && dmem_recv && dmem_ack;

    always_comb begin
        dmem_wen   = 1'b0;
        dmem_strb  = 4'h0;
        dmem_addr  = 32'h0;
        dmem_wdata = 32'h0;
        dmem_ack   = 1'b0;
        p0_gnt     = 1'b0;
        p0_recv    = 1'b0;
        p0_error   = 1'b0;
        p0_rdata   = 32'h0;
        p1_gnt     = 1'b0;
        p1_recv    = 1'b0;
        p1_error   = 1'b0;
        p1_rdata   = 32'h0;
        if (!g_reset) begin
            dmem_wen   = sel ? p1_wen   : p0_wen;
            dmem_strb  = sel ? p1_strb  : p0_strb;
            dmem_addr  = sel ? p1_addr  : p0_addr;
            dmem_wdata = sel ? p1_wdata : p0_wdata;
            p0_gnt     = push && !sel;
            p1_gnt     = push &&  sel;
            // Responses with nothing outstanding are dropped silently.
            if (!empty) begin
                if (head_id) begin
                    p1_recv  = dmem_recv;
                    p1_error = dmem_error;
                    p1_rdata = dmem_rdata;
                    dmem_ack = p1_ack;
                end else begin
                    p0_recv  = dmem_recv;
                    p0_error = dmem_error;
                    p0_rdata = dmem_rdata;
                    dmem_ack = p0_ack;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            lock_q <= 1'b0;
            sel_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Set on a stalled request, cleared on the accepting cycle.
            lock_q <= dmem_req && !dmem_gnt;
            sel_q  <= sel;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: ID storage is not reset; count==0 makes stale entries unreachable.
    always_ff @(posedge g_clk) begin
        if (push)
            id_mem[wr_ptr] <= sel;
    end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_frv_dmem_arbiter
//
// Directed bench for frv_dmem_arbiter. A behavioural model (queue of
// outstanding port IDs, a stalled-request memory and a favoured-port bit)
// predicts every output each cycle; directed sequences add hand-computed
// literal expectations. Honours FRV_DMEM_ARB_RR_EN like the design.
// ---------------------------------------------------------------------------
module tb_frv_dmem_arbiter;

    localparam int OUTSTANDING = 2;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        p0_req, p0_wen, p0_ack;
    logic [3:0]  p0_strb;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_recv, p0_error;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_wen, p1_ack;
    logic [3:0]  p1_strb;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_recv, p1_error;
    logic [31:0] p1_rdata;
    logic        dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_error, dmem_ack;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

    int n_vec = 0;
    int n_mis = 0;
    bit model_on = 1'b0;

    always #5 g_clk = ~g_clk;

    frv_dmem_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
        .g_clk(g_clk), .g_reset(g_reset),
        .p0_req(p0_req), .p0_wen(p0_wen), .p0_strb(p0_strb), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_recv(p0_recv), .p0_error(p0_error),
        .p0_rdata(p0_rdata), .p0_ack(p0_ack),
        .p1_req(p1_req), .p1_wen(p1_wen), .p1_strb(p1_strb), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_recv(p1_recv), .p1_error(p1_error),
        .p1_rdata(p1_rdata), .p1_ack(p1_ack),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_recv(dmem_recv), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_q[$];          // port IDs of granted, unanswered transactions
    bit  m_stalled;       // last cycle's request was not accepted
    int  m_stall_port;
    int  m_fav;           // favoured port on contention (round-robin only)
    int  m_port;
    bit  m_req;
    logic [12:0] e_ctrl;
    logic [31:0] e_addr, e_wdata, e_r0, e_r1;
    bit  e_g0, e_g1, e_v0, e_v1, e_er0, e_er1, e_ack, e_wen;
    logic [3:0] e_strb;

    always @(negedge g_clk) begin
        if (model_on) begin
            {e_g0, e_g1, e_v0, e_v1, e_er0, e_er1, e_ack, e_wen, m_req} = '0;
            e_strb = '0; e_addr = '0; e_wdata = '0; e_r0 = '0; e_r1 = '0;
            m_port = 0;
            if (!g_reset) begin
                if (m_stalled) m_port = m_stall_port;
`ifdef FRV_DMEM_ARB_RR_EN
                else if (p0_req && p1_req) m_port = m_fav;
`else
                else if (p0_req && p1_req) m_port = 0;
`endif
                else if (p1_req) m_port = 1;
                m_req   = ((m_port == 1) ? p1_req : p0_req) && (m_q.size() < OUTSTANDING);
                e_wen   = (m_port == 1) ? p1_wen   : p0_wen;
                e_strb  = (m_port == 1) ? p1_strb  : p0_strb;
                e_addr  = (m_port == 1) ? p1_addr  : p0_addr;
                e_wdata = (m_port == 1) ? p1_wdata : p0_wdata;
                e_g0 = m_req && dmem_gnt && (m_port == 0);
                e_g1 = m_req && dmem_gnt && (m_port == 1);
                if (m_q.size() > 0) begin
                    if (m_q[0] == 1) begin
                        e_v1 = dmem_recv; e_er1 = dmem_error; e_r1 = dmem_rdata; e_ack = p1_ack;
                    end else begin
                        e_v0 = dmem_recv; e_er0 = dmem_error; e_r0 = dmem_rdata; e_ack = p0_ack;
                    end
                end
            end
            e_ctrl = {e_g0, e_v0, e_er0, e_g1, e_v1, e_er1, m_req, e_wen, e_ack, e_strb};
            check("ctrl", 64'({p0_gnt, p0_recv, p0_error, p1_gnt, p1_recv, p1_error,
                              dmem_req, dmem_wen, dmem_ack, dmem_strb}), 64'(e_ctrl));
            check("addr", 64'(dmem_addr), 64'(e_addr));
            check("wdata", 64'(dmem_wdata), 64'(e_wdata));
            check("p0_rdata", 64'(p0_rdata), 64'(e_r0));
            check("p1_rdata", 64'(p1_rdata), 64'(e_r1));
            // advance model state to what the coming edge commits
            if (g_reset) begin
                m_q.delete();
                m_stalled = 1'b0;
                m_fav = 0;
            end else begin
                if (m_q.size() > 0 && dmem_recv && e_ack) void'(m_q.pop_front());
                if (m_req && dmem_gnt) begin
                    m_q.push_back(m_port);
                    m_fav = 1 - m_port;
                end
                m_stalled    = m_req && !dmem_gnt;
                m_stall_port = m_port;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic idle();
        {p0_req, p0_wen, p0_ack, p1_req, p1_wen, p1_ack} = '0;
        {dmem_gnt, dmem_recv, dmem_error} = '0;
        p0_strb = 4'h0; p0_addr = '0; p0_wdata = '0;
        p1_strb = 4'h0; p1_addr = '0; p1_wdata = '0;
        dmem_rdata = '0;
    endtask

    task automatic do_reset();
        g_reset = 1'b1;
        step();
        g_reset = 1'b0;
    endtask

    initial begin
        g_reset = 1'b1;
        idle();
        p0_req = 1'b1;             // must not leak through while in reset
        p0_addr = 32'h0000_0040;
        step();
        model_on = 1'b1;
        @(negedge g_clk);
        check("rst_dmem_req", 64'(dmem_req), 64'h0);
        check("rst_dmem_addr", 64'(dmem_addr), 64'h0);
        check("rst_p0_gnt", 64'(p0_gnt), 64'h0);
        step();
        g_reset = 1'b0;
        idle();

        // single p0 load, granted immediately, answered next cycle
        p0_req = 1'b1; p0_addr = 32'h0000_2000; p0_strb = 4'hf; dmem_gnt = 1'b1;
        @(negedge g_clk);
        check("t1_p0_gnt", 64'(p0_gnt), 64'h1);
        check("t1_addr", 64'(dmem_addr), 64'h2000);
        step();
        idle();
        dmem_recv = 1'b1; dmem_rdata = 32'hDEAD_BEEF; p0_ack = 1'b1;
        @(negedge g_clk);
        check("t1_p0_recv", 64'(p0_recv), 64'h1);
        check("t1_p0_rdata", 64'(p0_rdata), 64'hDEAD_BEEF);
        check("t1_p1_all", 64'({p1_gnt, p1_recv, p1_error, p1_rdata}), 64'h0);
        step();
        idle();

        // p1 stalled three cycles, p0 arrives in cycle 2: p1 held until granted
        p1_req = 1'b1; p1_addr = 32'h0000_0100;
        step();
        step();
        p0_req = 1'b1; p0_addr = 32'h0000_0200;
        @(negedge g_clk);
        check("t2_held_addr", 64'(dmem_addr), 64'h100);
        step();
        dmem_gnt = 1'b1;
        @(negedge g_clk);
        check("t2_gnt", 64'({p0_gnt, p1_gnt}), 64'b01);
        step();
        p1_req = 1'b0;
        @(negedge g_clk);
        check("t2_gnt_p0", 64'({p0_gnt, p1_gnt}), 64'b10);
        step();
        idle();
        dmem_recv = 1'b1; dmem_rdata = 32'h0000_0A01; p0_ack = 1'b1; p1_ack = 1'b1;
        @(negedge g_clk);
        check("t2_resp1", 64'({p0_recv, p1_recv}), 64'b01);
        step();
        dmem_rdata = 32'h0000_0A02;
        @(negedge g_clk);
        check("t2_resp2", 64'({p0_recv, p1_recv}), 64'b10);
        step();
        idle();

        // continuous contention for four grants, responses streamed behind
        do_reset();
        p0_req = 1'b1; p1_req = 1'b1; p0_addr = 32'h3000; p1_addr = 32'h4000;
        dmem_gnt = 1'b1; p0_ack = 1'b1; p1_ack = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                dmem_recv = 1'b1;
                dmem_rdata = 32'h100 + 32'(k);
            end
            @(negedge g_clk);
`ifdef FRV_DMEM_ARB_RR_EN
            check($sformatf("t3_rr_gnt%0d", k), 64'({p0_gnt, p1_gnt}), (k % 2 == 0) ? 64'b10 : 64'b01);
`else
            check($sformatf("t3_fix_gnt%0d", k), 64'({p0_gnt, p1_gnt}), 64'b10);
`endif
            step();
        end
        p0_req = 1'b0; p1_req = 1'b0; dmem_gnt = 1'b0;
        step();
        idle();

        // FIFO full: third request waits until the cycle after the first pop
        p0_req = 1'b1; p0_addr = 32'h5000; dmem_gnt = 1'b1;
        step();
        p0_req = 1'b0; p1_req = 1'b1; p1_addr = 32'h6000;
        @(negedge g_clk);
        check("t4_gnt_p1", 64'(p1_gnt), 64'h1);
        step();
        p1_req = 1'b0; p0_req = 1'b1; p0_addr = 32'h7000;
        @(negedge g_clk);
        check("t4_full_req", 64'(dmem_req), 64'h0);
        step();
        dmem_recv = 1'b1; dmem_rdata = 32'h11; p0_ack = 1'b1;
        @(negedge g_clk);
        check("t4_pop_blocks", 64'({dmem_req, p0_recv}), 64'b01);
        step();
        p0_ack = 1'b0; p1_ack = 1'b1; dmem_rdata = 32'h22;
        @(negedge g_clk);
        check("t4_third_gnt", 64'({p0_gnt, p1_recv, p1_rdata}), {30'h0, 1'b1, 1'b1, 32'h22});
        step();
        p0_req = 1'b0; dmem_gnt = 1'b0; p0_ack = 1'b1; p1_ack = 1'b0; dmem_rdata = 32'h33;
        @(negedge g_clk);
        check("t4_third_resp", 64'({p0_recv, p0_rdata}), {31'h0, 1'b1, 32'h33});
        step();
        idle();

        // response back-pressure and error routing on port 1
        p1_req = 1'b1; p1_wen = 1'b1; p1_strb = 4'h3; p1_wdata = 32'hCAFE_0001; dmem_gnt = 1'b1;
        @(negedge g_clk);
        check("t5_wdata", 64'({dmem_wen, dmem_strb, dmem_wdata}), {27'h0, 1'b1, 4'h3, 32'hCAFE_0001});
        step();
        idle();
        dmem_recv = 1'b1; dmem_error = 1'b1;
        @(negedge g_clk);
        check("t5_hold", 64'({p1_recv, p1_error, dmem_ack}), 64'b110);
        step();
        p1_ack = 1'b1;
        @(negedge g_clk);
        check("t5_ack", 64'(dmem_ack), 64'h1);
        step();
        idle();

        // reset with two outstanding, then a stray response
        p0_req = 1'b1; dmem_gnt = 1'b1;
        step();
        p0_req = 1'b0; p1_req = 1'b1;
        step();
        idle();
        g_reset = 1'b1; dmem_recv = 1'b1; p0_ack = 1'b1; p1_ack = 1'b1;
        @(negedge g_clk);
        check("t6_in_rst", 64'({p0_recv, p1_recv, dmem_ack}), 64'h0);
        step();
        g_reset = 1'b0;
        @(negedge g_clk);
        check("t6_stray", 64'({p0_recv, p1_recv, dmem_ack}), 64'h0);
        step();
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/frv_dmem_arbiter.md
FRV_DMEM_ARBITER -- requirements
Module: frv_dmem_arbiter

Interface
REQ-001 SHALL have parameter OUTSTANDING, default 2, meaning the maximum number of granted-but-unanswered dmem transactions (a power of two, at least 2).
REQ-002 SHALL have port g_clk  in  1  the single clock.
REQ-003 SHALL have port g_reset  in  1  reset; the reset is synchronous and active-high.
REQ-004 SHALL have ports p0_req/p0_wen  in  1 each  port-0 (LSU) request and write enable.
REQ-005 SHALL have ports p0_strb  in  4, and p0_addr/p0_wdata  in  32 each  port-0 byte strobe, address and write data.
REQ-006 SHALL have ports p0_gnt/p0_recv/p0_error  out  1 each, and p0_rdata  out  32  port-0 grant, response valid, response error and read data.
REQ-007 SHALL have port p0_ack  in  1  port-0 response accept.
REQ-008 SHALL have port-1 (secondary requester) signals p1_* identical to REQ-004..REQ-007.
REQ-009 SHALL have downstream ports dmem_req/dmem_wen  out  1 each, dmem_strb  out  4, dmem_addr/dmem_wdata  out  32 each, and dmem_gnt  in  1.
REQ-010 SHALL have downstream response ports dmem_recv/dmem_error  in  1 each, dmem_rdata  in  32, and dmem_ack  out  1.

Function
REQ-011 SHALL drive dmem_req/wen/strb/addr/wdata combinationally from the selected port (sel), and drive dmem_req low when no port requests or the ID FIFO is full.
REQ-012 SHALL assert pN_gnt only when dmem_gnt is high, sel==N and dmem_req is high; the non-selected port's gnt SHALL be 0.
REQ-013 SHALL, when dmem_req is high and dmem_gnt is low, set a lock register so that sel is held on the following cycle regardless of the other port, with no switching mid-request.
REQ-014 SHALL clear the lock on the cycle dmem_req && dmem_gnt is true.
REQ-015 SHALL, when unlocked with both ports requesting, select by priority (REQ-033/034); with one port requesting it SHALL select that port.
REQ-016 SHALL push the sel ID into an OUTSTANDING-deep ID FIFO on every dmem_req && dmem_gnt cycle.
REQ-017 SHALL, when the FIFO is non-empty, route dmem_recv/dmem_error/dmem_rdata to the port named by the FIFO head (other port: recv=0, error=0, rdata=0) and set dmem_ack = that port's pN_ack.
REQ-018 SHALL pop the FIFO head on dmem_recv && dmem_ack.
REQ-019 SHALL, when full, block pushes even if a pop occurs in the same cycle (dmem_req=0); the request is accepted on a later cycle.
REQ-020 SHALL, when not full, perform a simultaneous push and pop in one cycle with the count unchanged, and SHALL give correct routing when the head and tail IDs differ.
REQ-021 SHALL, when empty, drop dmem_recv (no pN_recv, dmem_ack=0).
REQ-022 SHALL wrap the FIFO pointers modulo OUTSTANDING.
REQ-023 SHALL add zero latency on the request and response paths, and one cycle from grant to the earliest routable response.

Reset
REQ-024 SHALL, on g_reset high at a clock edge, empty the FIFO, clear the lock and set round-robin priority to port 0.
REQ-025 SHALL hold all outputs at 0 (dmem_req, dmem_ack, pN_gnt, pN_recv, pN_error, pN_rdata and dmem_* fields) while g_reset is high.
REQ-026 SHALL discard outstanding IDs on reset mid-operation; responses arriving after reset SHALL be handled per REQ-021.

Configuration
REQ-027 SHALL use the macro FRV_DMEM_ARB_RR_EN to select round-robin arbitration.
REQ-028 SHALL, without FRV_DMEM_ARB_RR_EN, use fixed priority: port 0 wins any unlocked contention, with no priority state register.
REQ-029 SHALL, with FRV_DMEM_ARB_RR_EN, keep a 1-bit priority register that is updated after each grant to favour the other port.
REQ-030 SHALL have identical lock, FIFO and reset behaviour in both configurations.

Verification
REQ-031 SHALL verify: single p0 load at 0x0000_2000, dmem_gnt in the same cycle, recv next cycle with rdata 0xDEADBEEF -> p0_gnt=1, p0_recv=1, p0_rdata=0xDEADBEEF, p1 all-zero.
REQ-032 SHALL verify: p1 requests, dmem_gnt low 3 cycles, p0 requests in cycle 2 -> sel stays on p1 until granted, then p0 is granted.
REQ-033 SHALL verify: with RR disabled, both ports request continuously for 4 grants -> all 4 go to p0.
REQ-034 SHALL verify: with FRV_DMEM_ARB_RR_EN defined, both ports request continuously for 4 grants -> p0, p1, p0, p1.
REQ-035 SHALL verify: grants to p0 then p1 with no response, a third request pending -> dmem_req=0; in-order responses go to p0 then p1; the third request is granted the cycle after the first pop.
REQ-036 SHALL verify: g_reset asserted with 2 outstanding, then a stray dmem_recv -> no pN_recv and dmem_ack=0.
